// File: rtl/adder_pkg.sv
// Shared types and default sizing for the pipelined add/subtract unit.
package adder_pkg;

    typedef enum logic {
        ADD_OP = 1'b0,
        SUB_OP = 1'b1
    } adder_op_t;

    localparam int unsigned DEFAULT_WORD_WIDTH = 32;
    localparam int unsigned DEFAULT_NUM_STAGES = 4;

endpackage

// File: rtl/adder_segment.sv
// Combinational segment adder: one slice of the segmented carry chain.
// msb_cin is the carry into the top bit, used for signed overflow.
module adder_segment #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    // sum = a ^ b ^ carry-in at each bit, so the MSB carry-in falls out directly.
    assign msb_cin = a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1];

endmodule

// File: rtl/pipelined_adder_unit.sv
// Pipelined add/subtract unit: one carry-chain segment per stage, valid/ready on both sides.
// Operands and partial results travel with each beat; results leave in acceptance order.
module pipelined_adder_unit
    import adder_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op,
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] y,
    output logic                  cout,
    output logic                  ovf
);

    if (NUM_STAGES == 0 || (WORD_WIDTH % NUM_STAGES) != 0) begin : g_param_check
        $error("NUM_STAGES must be at least 1 and divide WORD_WIDTH");
    end

    localparam int unsigned SEG_WIDTH = WORD_WIDTH / NUM_STAGES;

    adder_op_t op_e;

    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] adv;
    logic [NUM_STAGES-1:0] src_valid;

    // Index s is the input side of stage s; index NUM_STAGES is the last stage's registers.
    logic [WORD_WIDTH-1:0] op_a [NUM_STAGES+1];
    logic [WORD_WIDTH-1:0] op_b [NUM_STAGES+1];
    logic [WORD_WIDTH-1:0] op_y [NUM_STAGES+1];
    logic [NUM_STAGES:0]   op_c;
    logic                  ovf_q;

    assign op_e    = adder_op_t'(op);
    assign op_a[0] = a;
    assign op_b[0] = (op_e == SUB_OP) ? ~b : b;
    assign op_c[0] = (op_e == SUB_OP);
    assign op_y[0] = '0;

    // A stage moves when it is empty or its successor moves, so bubbles collapse.
    always_comb begin
        adv       = '0;
        src_valid = '0;
        adv[NUM_STAGES-1] = !valid_q[NUM_STAGES-1] || out_ready;
        for (int s = NUM_STAGES - 2; s >= 0; s--) begin
            adv[s] = !valid_q[s] || adv[s+1];
        end
        src_valid[0] = in_valid;
        for (int s = 1; s < NUM_STAGES; s++) begin
            src_valid[s] = valid_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (adv[s]) begin
                    valid_q[s] <= src_valid[s];
                end
            end
        end
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        logic [SEG_WIDTH-1:0]  seg_sum;
        logic                  seg_cout;
        logic                  seg_msb_cin;
        logic [WORD_WIDTH-1:0] y_d;
        logic [WORD_WIDTH-1:0] a_q;
        logic [WORD_WIDTH-1:0] b_q;
        logic [WORD_WIDTH-1:0] y_q;
        logic                  c_q;

        adder_segment #(
            .WIDTH(SEG_WIDTH)
        ) u_segment (
            .a      (op_a[s][s*SEG_WIDTH +: SEG_WIDTH]),
            .b      (op_b[s][s*SEG_WIDTH +: SEG_WIDTH]),
            .cin    (op_c[s]),
            .sum    (seg_sum),
            .cout   (seg_cout),
            .msb_cin(seg_msb_cin)
        );

        always_comb begin
            y_d = op_y[s];
            y_d[s*SEG_WIDTH +: SEG_WIDTH] = seg_sum;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                a_q <= '0;
                b_q <= '0;
                y_q <= '0;
                c_q <= 1'b0;
            end else if (adv[s] && src_valid[s]) begin
                a_q <= op_a[s];
                b_q <= op_b[s];
                y_q <= y_d;
                c_q <= seg_cout;
            end
        end

        assign op_a[s+1] = a_q;
        assign op_b[s+1] = b_q;
        assign op_y[s+1] = y_q;
        assign op_c[s+1] = c_q;

        if (s == NUM_STAGES - 1) begin : g_flags
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ovf_q <= 1'b0;
                end else if (adv[s] && src_valid[s]) begin
                    ovf_q <= seg_msb_cin ^ seg_cout;
                end
            end
        end else begin : g_no_flags
            logic unused_msb_cin;
            assign unused_msb_cin = seg_msb_cin;
        end
    end

    // Operands are fully consumed by the last stage.
    logic unused_tail;
    assign unused_tail = ^{op_a[NUM_STAGES], op_b[NUM_STAGES]};

    assign in_ready  = adv[0];
    assign out_valid = valid_q[NUM_STAGES-1];
    assign y         = op_y[NUM_STAGES];
    assign cout      = op_c[NUM_STAGES];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_unit.sv
// Scoreboard bench for pipelined_adder_unit: directed corner cases, timing, stall, reset
// and randomized traffic against an integer-arithmetic reference model.
module tb_pipelined_adder_unit;
    import adder_pkg::*;

    localparam int unsigned W = DEFAULT_WORD_WIDTH;
    localparam int unsigned N = DEFAULT_NUM_STAGES;
    localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (W - 1));

    typedef struct packed {
        logic [W-1:0] y;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    int   n_dropped = 0;
    int   last_acc = 0;
    bit   skip_hold = 1'b0;
    exp_t sb[$];

    pipelined_adder_unit #(
        .WORD_WIDTH(W),
        .NUM_STAGES(N)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] z);
        longint unsigned ux = 64'(x);
        longint unsigned uz = 64'(z);
        longint          sx = longint'($signed(x));
        longint          sz = longint'($signed(z));
        longint unsigned u;
        longint          s;
        exp_t            e;
        if (o == SUB_OP) begin
            u   = ux - uz;
            s   = sx - sz;
            e.c = (ux >= uz);
        end else begin
            u   = ux + uz;
            s   = sx + sz;
            e.c = ((u >> W) != 0);
        end
        e.y = u[W-1:0];
        e.v = (s > SMAX) || (s < SMIN);
        return e;
    endfunction

    task automatic send(input logic o, input logic [W-1:0] x, input logic [W-1:0] z,
                        input exp_t e);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = z;
        #1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
        end else begin
            sb.push_back(e);
            n_pushed++;
            last_acc = cyc + 1;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            #3;
            t++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: pops on every output handshake and checks hold-while-stalled.
    initial begin : monitor
        exp_t         e;
        logic         held;
        logic [W+1:0] hold_val;
        held = 1'b0;
        hold_val = '0;
        forever begin
            @(negedge clk);
            #2;
            if (held && !skip_hold) begin
                check("stall_hold", {out_valid, y, cout, ovf}, {1'b1, hold_val});
            end
            held = out_valid && !out_ready;
            hold_val = {y, cout, ovf};
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    n_popped++;
                    check("result", {y, cout, ovf}, e);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int           acc0;
        int           seen;
        int           run;
        int           base;
        int           t;
        bit           done;
        logic [W-1:0] y_hold;

        // Reset state, asserted asynchronously.
        #2 reset_n = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;

        // Directed corner cases.
        send(ADD_OP, 32'hFFFF_FFFF, 32'h0000_0001, exp_t'({32'h0000_0000, 1'b1, 1'b0}));
        send(SUB_OP, 32'd5, 32'd7, exp_t'({32'hFFFF_FFFE, 1'b0, 1'b0}));
        send(SUB_OP, 32'd7, 32'd5, exp_t'({32'h0000_0002, 1'b1, 1'b0}));
        send(ADD_OP, 32'h7FFF_FFFF, 32'h0000_0001, exp_t'({32'h8000_0000, 1'b0, 1'b1}));
        send(SUB_OP, 32'h8000_0000, 32'h0000_0001, exp_t'({32'h7FFF_FFFF, 1'b1, 1'b1}));
        idle();
        wait_drain();

        // Back-to-back beats: latency and gap-free output.
        acc0 = 0;
        seen = 0;
        run = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(logic'(i % 2), W'(i), W'(i), model(logic'(i % 2), W'(i), W'(i)));
                    if (i == 0) acc0 = last_acc;
                end
                idle();
            end
            begin
                t = 0;
                @(negedge clk);
                #3;
                while (!out_valid && t < 40) begin
                    @(negedge clk);
                    #3;
                    t++;
                end
                seen = cyc;
                while (out_valid && run < 20) begin
                    run++;
                    @(negedge clk);
                    #3;
                end
            end
        join
        check("first_latency", seen - acc0, N - 1);
        check("b2b_run", run, 8);
        wait_drain();

        // Stall: six cycles of out_ready low with beats pending.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(logic'(i % 3 == 0), W'(32'h1000_0000 * i + 3), W'(i * 77),
                         model(logic'(i % 3 == 0), W'(32'h1000_0000 * i + 3), W'(i * 77)));
                end
                idle();
            end
            begin
                @(negedge clk);
                out_ready = 1'b0;
                base = n_pushed;
                repeat (4) @(negedge clk);
                #2;
                check("stall_out_valid", out_valid, 1);
                y_hold = y;
                @(negedge clk);
                #2;
                check("stall_accepted", n_pushed - base, N);
                check("stall_in_ready", in_ready, 0);
                check("stall_y_stable", y, y_hold);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with three beats in flight.
        @(negedge clk);
        out_ready = 1'b0;
        send(ADD_OP, 32'h9000_0000, 32'h9000_0000, model(ADD_OP, 32'h9000_0000, 32'h9000_0000));
        send(ADD_OP, 32'h1111_1111, 32'h2222_2222, model(ADD_OP, 32'h1111_1111, 32'h2222_2222));
        send(SUB_OP, 32'h0000_0010, 32'h0000_0001, model(SUB_OP, 32'h0000_0010, 32'h0000_0001));
        idle();
        t = 0;
        #3;
        while (!out_valid && t < 40) begin
            @(negedge clk);
            #3;
            t++;
        end
        check("inflight_valid", out_valid, 1);
        skip_hold = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_y", y, 0);
        check("async_rst_cout", cout, 0);
        check("async_rst_ovf", ovf, 0);
        n_dropped += sb.size();
        sb.delete();
        #1 reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        send(ADD_OP, 32'd3, 32'd4, exp_t'({32'h0000_0007, 1'b0, 1'b0}));
        idle();
        skip_hold = 1'b0;
        wait_drain();
        repeat (N + 2) @(negedge clk);
        #3;
        check("no_stale", out_valid, 0);

        // Randomized traffic with random backpressure and input gaps.
        done = 1'b0;
        fork
            begin
                logic         o;
                logic [W-1:0] x;
                logic [W-1:0] z;
                for (int i = 0; i < 300; i++) begin
                    o = 1'($urandom_range(0, 1));
                    x = $urandom;
                    z = $urandom;
                    if ($urandom_range(0, 7) == 0) x = 32'h7FFF_FFFF;
                    if ($urandom_range(0, 7) == 0) z = 32'h8000_0000;
                    if ($urandom_range(0, 3) == 0) idle();
                    send(o, x, z, model(o, x, z));
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("beat_conservation", n_popped + n_dropped, n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
